// File: rtl/cc_datapath_pkg.sv
// Shared datapath constants and scratchpad writer state encoding.
// Common to cc_scratchpad_writer and its decoder.
package cc_datapath_pkg;

    localparam int DATAWIDTH_BUS = 32;
    localparam int DATAWIDTH_SCRATCHPAD_DIRECTION = 5;
    localparam int DATAWIDTH_MIR_DIRECTION = 6;
    localparam int NUM_REGS = 16;
    localparam int R0_INDEX = 0;
    localparam int CLEAR_IDX_WIDTH = 4;

    localparam int DEST_WIDTH =
        (DATAWIDTH_MIR_DIRECTION > DATAWIDTH_SCRATCHPAD_DIRECTION)
        ? DATAWIDTH_MIR_DIRECTION
        : DATAWIDTH_SCRATCHPAD_DIRECTION;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } spwState_t;

endpackage

// File: rtl/cc_spw_decoder.sv
// Destination decoder: selects scratchpad or MIR address and
// produces a one-hot load enable (r0 never loaded) plus range flag.
module cc_spw_decoder
    import cc_datapath_pkg::*;
(
    input  logic                                      select,
    input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] scratchpadSel,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0]        mirSel,
    input  logic                                      valid,
    output logic [NUM_REGS-1:0]                       loadEn,
    output logic                                      outOfRange
);

    logic [DEST_WIDTH-1:0] dest;

    always_comb begin
        dest = select ? DEST_WIDTH'(mirSel)
                      : DEST_WIDTH'(scratchpadSel);
        outOfRange = valid && (dest >= DEST_WIDTH'(NUM_REGS));
        loadEn = '0;
        for (int k = R0_INDEX + 1; k < NUM_REGS; k++) begin
            loadEn[k] = valid && (dest == DEST_WIDTH'(k));
        end
    end

endmodule

// File: rtl/cc_scratchpad_writer.sv
// Scratchpad write side: register bank, write handshake, sequenced clear.
// Optional CC_SPW_WRITE_FORWARD_EN forwards accepted writes onto the bus.
module cc_scratchpad_writer
    import cc_datapath_pkg::*;
(
    input  logic                                      CC_SPW_CLOCK_50,
    input  logic                                      CC_SPW_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]                  CC_SPW_WrData_InBus,
    input  logic                                      CC_SPW_WrValid_In,
    output logic                                      CC_SPW_WrReady_Out,
    input  logic                                      CC_SPW_Select_In,
    input  logic [DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] CC_SPW_ScratchpadSelection_InBus,
    input  logic [DATAWIDTH_MIR_DIRECTION-1:0]        CC_SPW_MIRSelection_InBus,
    input  logic                                      CC_SPW_Clear_In,
    output logic [NUM_REGS*DATAWIDTH_BUS-1:0]         CC_SPW_Regs_OutBus,
    output logic                                      CC_SPW_Busy_Out,
    output logic                                      CC_SPW_WrError_Out
);

    logic [DATAWIDTH_BUS-1:0]   regBank [NUM_REGS];
    spwState_t                  state;
    spwState_t                  stateNext;
    logic [CLEAR_IDX_WIDTH-1:0] clearIdx;
    logic [CLEAR_IDX_WIDTH-1:0] clearIdxNext;
    logic                       wrError;
    logic                       wrAccept;
    logic [NUM_REGS-1:0]        loadEn;
    logic                       outOfRange;

    assign wrAccept = CC_SPW_WrValid_In && (state == IDLE);

    cc_spw_decoder uDecoder (
        .select        (CC_SPW_Select_In),
        .scratchpadSel (CC_SPW_ScratchpadSelection_InBus),
        .mirSel        (CC_SPW_MIRSelection_InBus),
        .valid         (wrAccept),
        .loadEn        (loadEn),
        .outOfRange    (outOfRange)
    );

    always_comb begin
        stateNext = state;
        clearIdxNext = clearIdx;
        unique case (state)
            IDLE: begin
                if (CC_SPW_Clear_In) begin
                    stateNext = CLEAR;
                    clearIdxNext = '0;
                end
            end
            CLEAR: begin
                // Index wraps back to 0 as the last register is cleared.
                clearIdxNext = clearIdx + 1'b1;
                if (clearIdx == CLEAR_IDX_WIDTH'(NUM_REGS - 1)) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                clearIdxNext = '0;
            end
        endcase
    end

    always_ff @(posedge CC_SPW_CLOCK_50) begin
        if (CC_SPW_RESET_InHigh) begin
            state <= IDLE;
            clearIdx <= '0;
            wrError <= 1'b0;
        end else begin
            state <= stateNext;
            clearIdx <= clearIdxNext;
            wrError <= wrAccept && outOfRange;
        end
    end

    always_ff @(posedge CC_SPW_CLOCK_50) begin
        for (int k = 0; k < NUM_REGS; k++) begin
            if (CC_SPW_RESET_InHigh) begin
                regBank[k] <= '0;
            end else if ((state == CLEAR) &&
                         (clearIdx == CLEAR_IDX_WIDTH'(k))) begin
                regBank[k] <= '0;
            end else if (loadEn[k]) begin
                regBank[k] <= CC_SPW_WrData_InBus;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : gRegsOut
`ifdef CC_SPW_WRITE_FORWARD_EN
        assign CC_SPW_Regs_OutBus[k*DATAWIDTH_BUS +: DATAWIDTH_BUS] =
            loadEn[k] ? CC_SPW_WrData_InBus : regBank[k];
`else
        assign CC_SPW_Regs_OutBus[k*DATAWIDTH_BUS +: DATAWIDTH_BUS] =
            regBank[k];
`endif
    end

    assign CC_SPW_WrReady_Out = (state == IDLE);
    assign CC_SPW_Busy_Out = (state == CLEAR);
    assign CC_SPW_WrError_Out = wrError;

endmodule

// File: doc/cc_scratchpad_writer.md
Name: cc_scratchpad_writer

Overview:
- Write side of the datapath scratchpad. It holds the 16 general registers (r0..r15) that the register read multiplexer selects from.
- It accepts write-back data through a valid/ready handshake. The destination is decoded from either the instruction (scratchpad) field or the MIR field.
- It exposes every register on a flat output bus.
- It provides a sequenced clear that zeroes the bank one register per cycle.

Parameters:
- DATAWIDTH_BUS, 32, width of each register and of the write data.
- DATAWIDTH_SCRATCHPAD_DIRECTION, 5, width of the instruction-field destination address.
- DATAWIDTH_MIR_DIRECTION, 6, width of the MIR destination address.
- NUM_REGS, 16, number of registers; fixed at 16 for this datapath.

Ports:
- CC_SPW_CLOCK_50  in  1  system clock, rising edge.
- CC_SPW_RESET_InHigh  in  1  synchronous, active-high reset.
- CC_SPW_WrData_InBus  in  DATAWIDTH_BUS  write-back data.
- CC_SPW_WrValid_In  in  1  write request valid.
- CC_SPW_WrReady_Out  out  1  writer can accept a request.
- CC_SPW_Select_In  in  1  0 = use scratchpad address, 1 = use MIR address.
- CC_SPW_ScratchpadSelection_InBus  in  DATAWIDTH_SCRATCHPAD_DIRECTION  instruction-field destination.
- CC_SPW_MIRSelection_InBus  in  DATAWIDTH_MIR_DIRECTION  MIR destination.
- CC_SPW_Clear_In  in  1  start a sequenced clear (level sampled in IDLE).
- CC_SPW_Regs_OutBus  out  NUM_REGS*DATAWIDTH_BUS  register k occupies bits [32k+31:32k].
- CC_SPW_Busy_Out  out  1  high while clearing.
- CC_SPW_WrError_Out  out  1  one-cycle pulse on an accepted out-of-range write.

Behaviour:
- Clock and reset: one clock, CC_SPW_CLOCK_50. Reset is synchronous and active-high on CC_SPW_RESET_InHigh.
- On reset:
  - All registers = 0.
  - FSM = IDLE, clear index = 0.
  - Busy_Out = 0, WrError_Out = 0, WrReady_Out = 1 (after the reset edge).
- Reset asserted mid-clear or mid-write: reset wins. The bank is zeroed and the FSM returns to IDLE on the same edge.
- Address selection:
  - dest = Select_In ? MIRSelection : zero-extended ScratchpadSelection.
  - Valid range is 0..15. Any dest >= 16 is out-of-range.
- FSM states: IDLE, CLEAR.
- IDLE:
  - WrReady_Out = 1, Busy_Out = 0.
  - On a clock edge with WrValid_In=1 the write is accepted.
  - If dest is 1..15, reg[dest] <= WrData.
  - If dest == 0, no write: r0 is hardwired zero.
  - If dest >= 16, no write and WrError_Out = 1 for the following cycle only.
  - Write latency: the new value is visible on Regs_OutBus one cycle after the accepting edge.
  - Clear_In=1 → CLEAR next cycle, index = 0.
  - Clear_In and WrValid_In both high: the write is accepted and performed, then CLEAR starts.
- CLEAR:
  - WrReady_Out = 0, Busy_Out = 1.
  - Each cycle reg[index] <= 0 and index increments.
  - After index 15 is cleared, return to IDLE. Busy lasts exactly 16 cycles.
  - WrValid_In is ignored (not accepted). Clear_In is ignored.
- Width rules: no arithmetic on data; data is stored unmodified.
- The index counter is 4 bits and wraps to 0 on exit.
- r0 always reads 0 on Regs_OutBus.

Optional Feature:
- Macro: CC_SPW_WRITE_FORWARD_EN.
- When defined: an accepted in-range write (dest 1..15) is also forwarded combinationally, so Regs_OutBus slice [dest] shows WrData in the same cycle as the accepting edge. Latency becomes 0 for readers.
- When undefined: latency is 1 cycle, and Regs_OutBus is purely register outputs.

Decomposition:
- Shared package (cc_datapath_pkg):
  - DATAWIDTH_* constants and NUM_REGS.
  - FSM state encoding: IDLE=1'b0, CLEAR=1'b1.
  - R0_INDEX=0.
- One sub-module, cc_spw_decoder, which is purely combinational:
  - Inputs: select, both addresses, valid.
  - Outputs: one-hot load enable [NUM_REGS-1:0], with bit 0 forced to 0, plus an out-of-range flag.
- The top holds the bank, the FSM and the clear counter.

Test Plan:
- Reset then idle → Regs_OutBus all 0, WrReady=1, Busy=0, WrError=0.
- Select=0, Scratchpad=5'd3, data 32'hDEADBEEF, valid 1 cycle → reg3 = DEADBEEF next cycle; all other registers 0.
- Select=1, MIR=6'd15, data 32'h12345678 → reg15 = 12345678. Then MIR=6'd0 with data FFFFFFFF → r0 remains 0.
- Select=1, MIR=6'd40, data 32'hAAAAAAAA → no register changes; WrError high exactly 1 cycle.
- Fill r1..r15 with index values, then assert Clear_In together with a write of 32'h55 to r2:
  - r2 = 55 first.
  - Busy high 16 cycles, WrReady=0 during them, and writes presented then are ignored.
  - All registers end at 0.
- Assert reset on clear cycle 6 → next cycle FSM IDLE, Busy=0, all registers 0, WrReady=1.
